// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 2-flop rx synchronizer, valid/ready word output.
// Define UART_RX_PARITY_EN to expect one parity bit (PARITY_ODD selects odd) before the stop bit.
// state  | meaning
// IDLE   | line idle, wait for a low sample on a tick
// START  | confirm start bit low at its centre
// DATA   | sample DATA_BITS bits at bit centre, LSB first
// PARITY | sample parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit, deliver word or flag framing error
module uart_rx #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   centre_start, centre_bit;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign centre_start = sample_tick && (tick_cnt_q == HALF_LAST);
  assign centre_bit   = sample_tick && (tick_cnt_q == BIT_LAST);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (sample_tick && !rx_sync_q) state_d = START;
      START:  if (centre_start) state_d = rx_sync_q ? IDLE : DATA;
      DATA: begin
        if (centre_bit && (bit_cnt_q == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (centre_bit) state_d = STOP;
`endif
      STOP:   if (centre_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q && !rx_ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      START: begin
        if (sample_tick) tick_cnt_d = centre_start ? '0 : tick_cnt_q + 1'b1;
      end
      DATA: begin
        if (centre_bit) begin
          tick_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end else if (sample_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (centre_bit) begin
          tick_cnt_d = '0;
          par_bad_d  = rx_sync_q ^ (^shift_q) ^ PAR_ODD;
        end else if (sample_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (centre_bit) begin
          tick_cnt_d = '0;
          if (rx_sync_q) begin
            // a same-clock handshake frees the slot, so only a stalled consumer overruns
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            overrun_d    = rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sample_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: tick_cnt_d = '0;
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
